// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//
// Sequential restoring divider. It produces one quotient bit per clock by
// shifting the partial remainder left and subtracting the divisor only when
// the result stays non-negative. It uses the same start/ready/done handshake
// as the shift-add multiplier, so one controlling FSM can drive either unit.
//
// Optional feature (macro SIGNED_DIV_EN):
//   undefined : pure unsigned division, no sign logic is built.
//   defined   : two's-complement operands. Magnitudes are taken at capture,
//               the same unsigned core runs, and the signs are fixed up on
//               entry to DONE (truncation toward zero).
//
// Parameters:
//   DW             operand/result width in bits (2..32)
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        request pulse, sampled only while ready_o=1
//   dividend_i     numerator, captured on the accept edge
//   divisor_i      denominator, captured on the accept edge
//   ready_o        high while idle and able to accept start_i
//   done_o         one-cycle pulse; results are valid from this cycle on
//   quotient_o     registered quotient
//   remainder_o    registered remainder
//   div_by_zero_o  error flag, valid with done_o
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          ready_o,
    output logic          done_o,
    output logic [DW-1:0] quotient_o,
    output logic [DW-1:0] remainder_o,
    output logic          div_by_zero_o
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    // The partial remainder is always below the divisor between iterations,
    // so its top bit is always zero. Only the low DW bits are stored and the
    // extra bit appears only in the shifted value used for the subtraction.
    logic [DW-1:0] rem_q;
    logic [DW-1:0] quo_q;
    logic [DW-1:0] dvs_q;
    logic [DW-1:0] quotient_q;
    logic [DW-1:0] remainder_q;
    logic          dbz_q;

    logic [DW:0]   shifted_d;
    logic [DW:0]   trial_d;
    logic [DW-1:0] remNext_d;
    logic [DW-1:0] quoNext_d;
    logic [DW-1:0] dvdMag_d;
    logic [DW-1:0] dvsMag_d;
    logic [DW-1:0] quoRes_d;
    logic [DW-1:0] remRes_d;

    // One restoring iteration. The sign bit of the trial subtraction decides
    // whether the subtraction is kept and what the new quotient bit is.
    always_comb begin
        shifted_d = {rem_q, quo_q[DW-1]};
        trial_d   = shifted_d - {1'b0, dvs_q};
        quoNext_d = {quo_q[DW-2:0], ~trial_d[DW]};
        remNext_d = trial_d[DW] ? shifted_d[DW-1:0] : trial_d[DW-1:0];
    end

`ifdef SIGNED_DIV_EN
    logic negQuo_q;
    logic negRem_q;

    // The core always sees magnitudes. The most negative value maps to
    // itself, which is still correct when read as unsigned.
    always_comb begin
        dvdMag_d = dividend_i[DW-1] ? -dividend_i : dividend_i;
        dvsMag_d = divisor_i[DW-1]  ? -divisor_i  : divisor_i;
        quoRes_d = negQuo_q ? -quoNext_d : quoNext_d;
        remRes_d = negRem_q ? -remNext_d : remNext_d;
    end

    // The sign fix-up flags are captured together with the operands.
    // The quotient is negative when the operand signs differ. The remainder
    // follows the sign of the dividend.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            negQuo_q <= 1'b0;
            negRem_q <= 1'b0;
        end else if (state_q == IDLE && start_i) begin
            negQuo_q <= dividend_i[DW-1] ^ divisor_i[DW-1];
            negRem_q <= dividend_i[DW-1];
        end
    end
`else
    always_comb begin
        dvdMag_d = dividend_i;
        dvsMag_d = divisor_i;
        quoRes_d = quoNext_d;
        remRes_d = remNext_d;
    end
`endif

    // Control FSM and datapath registers.
    // The result registers load only on the edge that enters DONE, so an
    // aborted operation never shows partial results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (divisor_i == '0) begin
                            // Skip the iterations. The raw dividend is the
                            // remainder, even in signed mode.
                            state_q     <= DONE;
                            quotient_q  <= '1;
                            remainder_q <= dividend_i;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CW'(DW);
                            rem_q   <= '0;
                            quo_q   <= dvdMag_d;
                            dvs_q   <= dvsMag_d;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= remNext_d;
                    quo_q <= quoNext_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        quotient_q  <= quoRes_d;
                        remainder_q <= remRes_d;
                        dbz_q       <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o       = (state_q == IDLE);
    assign done_o        = (state_q == DONE);
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Scoreboard bench for seq_restoring_divider (DW=16). Stimulus pushes the
// hand-computed result and the cycle in which done is due. A separate monitor
// pops an entry on every done pulse and compares against it. It also treats
// any done pulse that has no queued entry as an error, which covers ignored
// starts and aborted operations. With SIGNED_DIV_EN defined, signed vectors
// replace the unsigned vectors whose meaning would change.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          ready;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          divByZero;

    typedef struct {
        logic [DW-1:0] quo;
        logic [DW-1:0] rem;
        logic          dbz;
        int            doneCycle;
    } exp_t;

    exp_t sbQueue[$];
    int   checkCount = 0;
    int   failCount  = 0;
    int   cycleCnt   = 0;
    logic prevDone   = 1'b0;

    seq_restoring_divider #(.DW(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .ready_o       (ready),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (divByZero)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter. Latency checks compare against it.
    always @(posedge clk) cycleCnt++;

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycleCnt);
        end
    endtask

    // Wait at the falling edge until the divider is idle, with a bound.
    task automatic waitReady();
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) checkOutput("readyTimeout", {31'd0, ready}, 32'd1);
    endtask

    // Issue one request. When pushExp is set, also queue the expected result.
    task automatic applyStimulus(input logic [DW-1:0] dvd, input logic [DW-1:0] dvs,
                                 input logic [DW-1:0] expQ, input logic [DW-1:0] expR,
                                 input logic expZ, input bit pushExp);
        exp_t e;
        waitReady();
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        if (pushExp) begin
            e.quo       = expQ;
            e.rem       = expR;
            e.dbz       = expZ;
            e.doneCycle = cycleCnt + 1 + (expZ ? 0 : DW);
            sbQueue.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor. It consumes expected entries when done pulses and checks the
    // ready behaviour around each pulse.
    always @(negedge clk) begin
        if (prevDone) checkOutput("readyAfterDone", {31'd0, ready}, 32'd1);
        if (rst !== 1'b1 && done === 1'b1) begin
            checkOutput("readyDuringDone", {31'd0, ready}, 32'd0);
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedDone", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbQueue.pop_front();
                checkOutput("quotient",    {16'd0, quotient},  {16'd0, e.quo});
                checkOutput("remainder",   {16'd0, remainder}, {16'd0, e.rem});
                checkOutput("divByZero",   {31'd0, divByZero}, {31'd0, e.dbz});
                checkOutput("doneLatency", cycleCnt,           e.doneCycle);
            end
        end
        prevDone = (done === 1'b1);
    end

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        checkOutput("rstReady",     {31'd0, ready},     32'd1);
        checkOutput("rstDone",      {31'd0, done},      32'd0);
        checkOutput("rstQuotient",  {16'd0, quotient},  32'd0);
        checkOutput("rstRemainder", {16'd0, remainder}, 32'd0);
        checkOutput("rstDivByZero", {31'd0, divByZero}, 32'd0);

        // Basic case, full-range dividend, divisor larger than dividend.
        applyStimulus(16'd100,  16'd7,      16'd14,     16'd2, 1'b0, 1'b1);
        applyStimulus(16'hFFFF, 16'h0001,   16'hFFFF,   16'd0, 1'b0, 1'b1);
`ifndef SIGNED_DIV_EN
        applyStimulus(16'd3,     16'hFFFF,  16'd0,      16'd3,  1'b0, 1'b1);
        applyStimulus(16'd40000, 16'd123,   16'd325,    16'd25, 1'b0, 1'b1);
`endif
        // Divide by zero, then a normal op that clears the flag.
        applyStimulus(16'd5,    16'd0,      16'hFFFF,   16'd5, 1'b1, 1'b1);
        applyStimulus(16'd9,    16'd3,      16'd3,      16'd0, 1'b0, 1'b1);

        // A start pulse while busy must be ignored, not queued.
        applyStimulus(16'd1000, 16'd10,     16'd100,    16'd0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        applyStimulus(16'd9,    16'd3,      16'd3,      16'd0, 1'b0, 1'b1);

        // Reset in the middle of an operation aborts it without a done pulse.
        applyStimulus(16'd50000, 16'd3,     16'd0,      16'd0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortReady",     {31'd0, ready},     32'd1);
        checkOutput("abortDone",      {31'd0, done},      32'd0);
        checkOutput("abortQuotient",  {16'd0, quotient},  32'd0);
        checkOutput("abortRemainder", {16'd0, remainder}, 32'd0);
        applyStimulus(16'd7,    16'd9,      16'd0,      16'd7, 1'b0, 1'b1);

        // Zero dividend and equal operands.
        applyStimulus(16'd0,    16'd5,      16'd0,      16'd0, 1'b0, 1'b1);
        applyStimulus(16'hFFFF, 16'hFFFF,   16'd1,      16'd0, 1'b0, 1'b1);

`ifdef SIGNED_DIV_EN
        // Signed vectors: truncation toward zero, wrap case, signed zero divide.
        applyStimulus(16'hFF9C, 16'd7,      16'hFFF2,   16'hFFFE, 1'b0, 1'b1);
        applyStimulus(16'd100,  16'hFFF9,   16'hFFF2,   16'd2,    1'b0, 1'b1);
        applyStimulus(16'h8000, 16'hFFFF,   16'h8000,   16'd0,    1'b0, 1'b1);
        applyStimulus(16'hFFFB, 16'd0,      16'hFFFF,   16'hFFFB, 1'b1, 1'b1);
`endif

        // Drain the scoreboard with a bound.
        n = 0;
        while (sbQueue.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pendingResults", sbQueue.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule
